// File: rtl/alu_exec.sv
// Execute-stage ALU with a 2-entry registered result FIFO and valid/ready handshakes.
// Define ALU_SHIFT_EN to enable codes 100 (SLL), 110 (SRL) and 111 (SRA).
module alu_exec #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUControl,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Illegal,
  output logic [TAGW-1:0]  out_tag
);

`ifdef ALU_SHIFT_EN
  localparam int unsigned ShW = $clog2(WIDTH);
  logic [ShW-1:0] shamt;
  assign shamt = SrcB[ShW-1:0];
`endif

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic             alu_zero;

  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (ALUControl)
      3'b000: alu_res = SrcA + SrcB;
      3'b001: alu_res = SrcA - SrcB;
      3'b010: alu_res = SrcA & SrcB;
      3'b011: alu_res = SrcA | SrcB;
      3'b101: alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_SHIFT_EN
      3'b100: alu_res = SrcA << shamt;
      3'b110: alu_res = SrcA >> shamt;
      3'b111: alu_res = $unsigned($signed(SrcA) >>> shamt);
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  assign alu_zero = (alu_res == '0);

  logic [WIDTH-1:0] res_q  [2];
  logic             zero_q [2];
  logic             ill_q  [2];
  logic [TAGW-1:0]  tag_q  [2];

  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       push, pop;

  // Handshake decisions depend only on registered occupancy.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = ~wr_ptr_q;
      if (pop)  rd_ptr_d = ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        res_q[i]  <= '0;
        zero_q[i] <= 1'b0;
        ill_q[i]  <= 1'b0;
        tag_q[i]  <= '0;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        res_q[wr_ptr_q]  <= alu_res;
        zero_q[wr_ptr_q] <= alu_zero;
        ill_q[wr_ptr_q]  <= alu_ill;
        tag_q[wr_ptr_q]  <= in_tag;
      end
    end
  end

  assign ALUResult = res_q[rd_ptr_q];
  assign Zero      = zero_q[rd_ptr_q];
  assign Illegal   = ill_q[rd_ptr_q];
  assign out_tag   = tag_q[rd_ptr_q];

endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed bench for alu_exec against a queue-based reference model.
module tb_alu_exec;
  localparam int unsigned W = 32;
  localparam int unsigned T = 5;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, out_ready;
  logic         in_ready, out_valid, Zero, Illegal;
  logic [W-1:0] SrcA, SrcB, ALUResult;
  logic [2:0]   ALUControl;
  logic [T-1:0] in_tag, out_tag;

  alu_exec #(.WIDTH(W), .TAGW(T)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .ALUControl(ALUControl),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .Illegal   (Illegal),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ill;
    logic [T-1:0] tag;
  } ent_t;

  ent_t q[$];
  bit   just_rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic ent_t alu_ref(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [2:0] op, input logic [T-1:0] tag);
    ent_t e;
    int   sa, sb;
    int   sh;
    sa = a;
    sb = b;
    sh = b % W;
    e.res = '0;
    e.ill = 1'b0;
    e.tag = tag;
    case (op)
      3'd0: e.res = a + b;
      3'd1: e.res = a - b;
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = (sa < sb) ? 1 : 0;
`ifdef ALU_SHIFT_EN
      3'd4: e.res = a << sh;
      3'd6: e.res = a >> sh;
      3'd7: e.res = sa >>> sh;
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic check_outputs();
    check_eq("in_ready", in_ready, q.size() != 2);
    check_eq("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check_eq("ALUResult", ALUResult, q[0].res);
      check_eq("Zero", Zero, q[0].z);
      check_eq("Illegal", Illegal, q[0].ill);
      check_eq("out_tag", out_tag, q[0].tag);
    end else if (just_rst) begin
      check_eq("rst_ALUResult", ALUResult, 0);
      check_eq("rst_Zero", Zero, 0);
      check_eq("rst_Illegal", Illegal, 0);
      check_eq("rst_out_tag", out_tag, 0);
    end
  endtask

  // One clock: update the model from pre-edge inputs, then check at the falling edge.
  task automatic cycle();
    bit   do_push, do_pop;
    ent_t e;
    e       = alu_ref(SrcA, SrcB, ALUControl, in_tag);
    do_push = in_valid && (q.size() != 2);
    do_pop  = out_ready && (q.size() != 0);
    @(posedge clk);
    if (reset) begin
      q.delete();
      just_rst = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        q.push_back(e);
        just_rst = 1'b0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] op, input logic [T-1:0] tag);
    in_valid   = v;
    SrcA       = a;
    SrcB       = b;
    ALUControl = op;
    in_tag     = tag;
  endtask

  task automatic op1(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op,
                     input logic [W-1:0] exp_res, input logic exp_z);
    drive(1'b1, a, b, op, 5'd1);
    cycle();
    check_eq("dir_res", ALUResult, exp_res);
    check_eq("dir_zero", Zero, exp_z);
    drive(1'b0, '0, '0, 3'd0, '0);
    cycle();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 3'd0, '0);
    @(negedge clk);
    cycle();
    cycle();
    check_eq("reset_in_ready", in_ready, 1);
    check_eq("reset_out_valid", out_valid, 0);
    reset = 1'b0;
    out_ready = 1'b1;

    op1(32'hFFFF_FFFF, 32'd1, 3'd0, 32'h0, 1'b1);
    op1(32'd5, 32'd7, 3'd1, 32'hFFFF_FFFE, 1'b0);
    op1(32'hF0F0, 32'hFF00, 3'd2, 32'hF000, 1'b0);
    op1(32'hF0F0, 32'h0F00, 3'd3, 32'hFFF0, 1'b0);
    op1(32'h8000_0000, 32'd1, 3'd5, 32'd1, 1'b0);
    op1(32'd1, 32'h8000_0000, 3'd5, 32'd0, 1'b1);
    op1(32'h1234, 32'h1234, 3'd5, 32'd0, 1'b1);

    drive(1'b1, 32'h8000_0000, 32'h24, 3'd7, 5'd2);
    cycle();
`ifdef ALU_SHIFT_EN
    check_eq("sra_res", ALUResult, 32'hF800_0000);
    check_eq("sra_ill", Illegal, 0);
`else
    check_eq("sra_res", ALUResult, 0);
    check_eq("sra_zero", Zero, 1);
    check_eq("sra_ill", Illegal, 1);
`endif
    drive(1'b0, '0, '0, 3'd0, '0);
    cycle();

    // Backpressure: two accepts fill the buffer, a third is refused.
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd2, 3'd0, 5'd3);
    cycle();
    check_eq("bp_in_ready1", in_ready, 1);
    drive(1'b1, 32'd3, 32'd4, 3'd0, 5'd7);
    cycle();
    check_eq("bp_in_ready2", in_ready, 0);
    drive(1'b1, 32'd9, 32'd9, 3'd0, 5'd9);
    cycle();
    check_eq("bp_hold_tag", out_tag, 3);
    check_eq("bp_hold_res", ALUResult, 3);
    drive(1'b0, '0, '0, 3'd0, '0);
    out_ready = 1'b1;
    cycle();
    check_eq("bp_tag2", out_tag, 7);
    check_eq("bp_ready_back", in_ready, 1);
    cycle();
    check_eq("bp_empty", out_valid, 0);

    // Flush at full occupancy with a same-cycle input.
    out_ready = 1'b0;
    drive(1'b1, 32'd1, 32'd1, 3'd0, 5'd4);
    cycle();
    drive(1'b1, 32'd2, 32'd2, 3'd0, 5'd5);
    cycle();
    flush = 1'b1;
    drive(1'b1, 32'd6, 32'd6, 3'd0, 5'd6);
    cycle();
    flush = 1'b0;
    check_eq("flush_out_valid", out_valid, 0);
    check_eq("flush_in_ready", in_ready, 1);
    drive(1'b0, '0, '0, 3'd0, '0);
    cycle();
    check_eq("flush_no_ghost", out_valid, 0);

    // Reset mid-stream.
    drive(1'b1, 32'd10, 32'd20, 3'd0, 5'd11);
    cycle();
    check_eq("mid_count1", out_valid, 1);
    reset = 1'b1;
    drive(1'b1, 32'd1, 32'd1, 3'd0, 5'd12);
    cycle();
    reset = 1'b0;
    check_eq("midrst_res", ALUResult, 0);
    check_eq("midrst_tag", out_tag, 0);
    check_eq("midrst_valid", out_valid, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
            3'($urandom_range(0, 7)), 5'($urandom));
      out_ready = $urandom_range(0, 2) != 0;
      flush     = $urandom_range(0, 15) == 0;
      reset     = $urandom_range(0, 63) == 0;
      cycle();
    end
    reset = 1'b0; flush = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage ALU for the RISC-V pipeline, the consumer of the 3-bit ALUControl code produced by the ALU decoder. It accepts one operation per cycle over a valid/ready handshake, computes the result and Zero flag, and holds results in a 2-entry output buffer. The buffer lets the downstream stage stall without combinational ready paths. It sits between the ID/EX pipeline register and the EX/MEM consumer.

## Interface
- WIDTH, 32, operand and result width in bits (power of two, ≥8)
- TAGW, 5, width of the pass-through destination tag (rd)

- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- flush  input  1  discard buffered results and any same-cycle input
- in_valid  input  1  operation present on inputs
- in_ready  output  1  block can accept an operation this cycle
- SrcA  input  WIDTH  operand A
- SrcB  input  WIDTH  operand B
- ALUControl  input  3  operation code
- in_tag  input  TAGW  destination tag, carried with the result
- out_valid  output  1  head result valid
- out_ready  input  1  downstream accepts head result
- ALUResult  output  WIDTH  head result
- Zero  output  1  head result is all zeros
- Illegal  output  1  head operation used an unsupported code
- out_tag  output  TAGW  head tag

## Operation
- Codes: 000 ADD, 001 SUB (A−B), 010 AND, 011 OR, 101 SLT (signed; result 1 or 0 zero-extended). 100, 110 and 111 are described under Configuration.
- ADD/SUB wrap modulo 2^WIDTH; no carry or overflow output.
- Unsupported code: ALUResult = 0, Zero = 1, Illegal = 1. The entry still occupies the buffer and is delivered normally.
- Buffer: 2-entry FIFO of {result, Zero, Illegal, tag}, with occupancy count 0..2.
- Push occurs when in_valid & in_ready & !flush. Pop occurs when out_valid & out_ready & !flush.
- in_ready = (count != 2). It depends only on registered state, never on out_ready or in_valid.
- out_valid = (count != 0). The head fields are driven from the register, not the combinational ALU.
- Simultaneous push and pop at count 1: count stays 1; the new entry becomes head next cycle.
- Simultaneous push and pop at count 2: cannot occur, because in_ready is 0.
- Order is strictly FIFO; the pointers wrap modulo 2.
- flush: count → 0 and both pointers → 0 next cycle. A same-cycle push and pop are ignored. flush takes priority over push and pop.
- reset: count → 0, pointers → 0. Storage is cleared so ALUResult = 0, Zero = 0, Illegal = 0, out_tag = 0.
- reset has priority over flush. Asserting reset mid-stream drops all entries.

## Timing
- Latency: an operation accepted on edge N is visible at out_valid/ALUResult after edge N (cycle N+1).
- Throughput: 1 op/cycle when out_ready is held high.
- Reset values: in_ready = 1, out_valid = 0, ALUResult = 0, Zero = 0, Illegal = 0, out_tag = 0.
- Head outputs stay stable while out_valid & !out_ready; they change only on pop, flush or reset.
- Backpressure: with out_ready = 0, two accepts fill the buffer and in_ready drops on the cycle after the second accept. On the first pop, in_ready returns to 1 on the following cycle.
- No combinational path from out_ready to in_ready, or from any input to any output.

## Configuration
- ALU_SHIFT_EN defined: 100 = SLL, 110 = SRL, 111 = SRA.
  - The shift amount is SrcB[log2(WIDTH)-1:0]; upper SrcB bits are ignored.
  - SRA replicates SrcA[WIDTH-1]. Illegal = 0 for these codes.
- ALU_SHIFT_EN undefined: 100, 110 and 111 are unsupported. They give ALUResult = 0, Zero = 1, Illegal = 1, and no shifter logic is present.

## Test plan
- Basic ops, out_ready = 1:
  - ADD 0xFFFFFFFF + 1 → 0, Zero = 1, one cycle later.
  - SUB 5 − 7 → 0xFFFFFFFE, Zero = 0.
  - AND 0xF0F0 & 0xFF00 → 0xF000.
  - OR 0xF0F0 | 0x0F00 → 0xFFF0.
- SLT signed: A = 0x80000000, B = 1 → 1. A = 1, B = 0x80000000 → 0. A = B → 0 with Zero = 1.
- Backpressure with out_ready = 0, two ops with tags 3 and 7:
  - in_ready drops to 0 and a third in_valid is not accepted; outputs hold tag 3.
  - Raise out_ready: tags 3 and 7 are delivered in order, and in_ready returns to 1.
- Flush at count = 2 with same-cycle in_valid: next cycle out_valid = 0 and in_ready = 1. The flushed input never appears.
- Reset mid-stream (count = 1, out_ready = 0): next cycle all outputs are at reset values.
- Shifts, code 111, SrcA = 0x80000000, SrcB = 0x24 (shamt 4):
  - ALU_SHIFT_EN defined: → 0xF8000000, Illegal = 0.
  - ALU_SHIFT_EN undefined: → 0, Zero = 1, Illegal = 1.
